bcd_up_counter: RTL and testbench

- Cascadable multi-digit BCD (decade) up-counter with parallel load and registered carry-out.
- Counterpart to the team's decade down-counter with borrow: counts 0→9 per digit, rippling carry across digits.
- Used as the increment side of timer/display chains; its CO feeds the EN of the next stage or a downstream down-counter.

---
 rtl/bcd_up_counter.sv | 67 ++++++
 tb/tb_bcd_up_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_up_counter.sv
// Cascadable multi-digit BCD up-counter with parallel load, registered carry-out
// and a combinational terminal-count for same-cycle cascade enabling.
module bcd_up_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_mr,
  input  logic                  i_en,
  input  logic                  i_ld,
  input  logic [4*DIGITS-1:0]   i_d,
  output logic [4*DIGITS-1:0]   o_q,
  output logic                  o_co,
  output logic                  o_tc_c
);

  localparam int unsigned QW = 4 * DIGITS;

  logic [QW-1:0] r_q;
  logic          r_co;

  logic [QW-1:0] w_q_inc;
  logic [QW-1:0] w_q_ld;
  logic          w_cy;
  logic          w_all9;

  // Explicit decade carry chain; an illegal digit selected to increment clears and carries.
  always_comb begin
    w_q_inc = '0;
    w_q_ld  = '0;
    w_cy    = 1'b1;
    w_all9  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_all9 = w_all9 & (r_q[4*i +: 4] == 4'd9);
      w_q_ld[4*i +: 4] = (i_d[4*i +: 4] > 4'd9) ? 4'd0 : i_d[4*i +: 4];
      if (w_cy) begin
        if (r_q[4*i +: 4] >= 4'd9) begin
          w_q_inc[4*i +: 4] = 4'd0;
          w_cy              = 1'b1;
        end else begin
          w_q_inc[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
          w_cy              = 1'b0;
        end
      end else begin
        w_q_inc[4*i +: 4] = r_q[4*i +: 4];
      end
    end
  end

  // Priority: reset > load > count > hold; CO is held when not counting.
  always_ff @(posedge i_clk or posedge i_mr) begin
    if (i_mr) begin
      r_q  <= '0;
      r_co <= 1'b0;
    end else if (i_ld) begin
      r_q  <= w_q_ld;
      r_co <= 1'b0;
    end else if (i_en) begin
      r_q  <= w_q_inc;
      r_co <= w_all9;
    end
  end

  assign o_q    = r_q;
  assign o_co   = r_co;
  assign o_tc_c = i_en & w_all9;

endmodule

// File: tb/tb_bcd_up_counter.sv
// Scoreboard bench for bcd_up_counter: directed vectors push expectations,
// a negedge monitor pops and compares them against Q, CO and TC.
module tb_bcd_up_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned QW     = 4 * DIGITS;

  typedef struct {
    int unsigned cyc;
    logic [QW-1:0] q;
    logic co;
    logic tc;
    string name;
  } exp_t;

  logic          clk;
  logic          mr;
  logic          en;
  logic          ld;
  logic [QW-1:0] d;
  logic [QW-1:0] q;
  logic          co;
  logic          tc;

  int unsigned cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sb[$];

  bcd_up_counter #(.DIGITS(DIGITS)) dut (
    .i_clk (clk),
    .i_mr  (mr),
    .i_en  (en),
    .i_ld  (ld),
    .i_d   (d),
    .o_q   (q),
    .o_co  (co),
    .o_tc_c(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per edge, compared on the following falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc) chk({e.name, "_late"}, 32'(cyc), 32'(e.cyc));
      chk({e.name, "_q"},  32'(q),  32'(e.q));
      chk({e.name, "_co"}, 32'(co), 32'(e.co));
      chk({e.name, "_tc"}, 32'(tc), 32'(e.tc));
    end
  end

  // Inputs change just after a falling edge and stay put until the next one.
  task automatic step(input string name, input logic l, input logic e,
                      input logic [QW-1:0] dv, input logic [QW-1:0] xq,
                      input logic xco, input logic xtc);
    exp_t x;
    @(negedge clk);
    #1;
    ld = l;
    en = e;
    d  = dv;
    x.cyc  = cyc + 1;
    x.q    = xq;
    x.co   = xco;
    x.tc   = xtc;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #1;
    mr = 1'b1;
    #1;
    chk({name, "_q_now"},  32'(q),  32'h0);
    chk({name, "_co_now"}, 32'(co), 32'h0);
    @(posedge clk);
    #1;
    chk({name, "_q_hold"}, 32'(q), 32'h0);
    @(negedge clk);
    #1;
    mr = 1'b0;
    en = 1'b0;
    ld = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mr = 1'b1;
    en = 1'b0;
    ld = 1'b0;
    d  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("por_q",  32'(q),  32'h0);
    chk("por_co", 32'(co), 32'h0);
    chk("por_tc", 32'(tc), 32'h0);
    mr = 1'b0;

    // count up from reset, then clear asynchronously with Q nonzero
    step("cnt1", 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);
    step("cnt2", 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0);
    step("cnt3", 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0);
    async_reset("mr_mid");
    step("rst_cnt1", 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);
    step("rst_cnt2", 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0);
    step("rst_cnt3", 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0);

    // carry ripple across digits
    step("ld0099",   1'b1, 1'b0, 16'h0099, 16'h0099, 1'b0, 1'b0);
    step("rip0100",  1'b0, 1'b1, 16'h0000, 16'h0100, 1'b0, 1'b0);
    step("ld0999",   1'b1, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0);
    step("rip1000",  1'b0, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0);

    // full wrap: TC on 9999 with EN, CO one step after
    step("ld9998",   1'b1, 1'b0, 16'h9998, 16'h9998, 1'b0, 1'b0);
    step("w9999",    1'b0, 1'b1, 16'h0000, 16'h9999, 1'b0, 1'b1);
    step("w0000",    1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("w0001",    1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);

    // hold keeps CO set; TC low at 9999 with EN low
    step("ld9999",   1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0);
    step("h_wrap",   1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step("hold",   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("h_resume", 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);

    // load priority over EN with illegal-digit scrub
    step("scrub",    1'b1, 1'b1, 16'h1A3F, 16'h1030, 1'b0, 1'b0);
    step("scrub_c",  1'b0, 1'b1, 16'h0000, 16'h1031, 1'b0, 1'b0);

    // load on the wrap edge wins; load also clears a set CO
    step("ld9999b",  1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0);
    step("ld_wrap",  1'b1, 1'b1, 16'h4567, 16'h4567, 1'b0, 1'b0);
    step("ld9999c",  1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0);
    step("c_wrap",   1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("ld_clrco", 1'b1, 1'b0, 16'h0042, 16'h0042, 1'b0, 1'b0);
    step("ld_hold",  1'b0, 1'b0, 16'h0000, 16'h0042, 1'b0, 1'b0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
